rms_window_accum: RTL and testbench
===================================

Name: rms_window_accum

Overview:
- Upstream feeder for the fixed-point square-root stage. Accepts a stream of signed 16-bit samples and squares each one.
- Accumulates the squares over a power-of-two window and divides by the window length with a shift.
- Emits the 32-bit mean-square word that the square-root stage turns into an RMS value.
- Provides valid/ready handshakes on both sides and a synchronous window flush.

Parameters:
- DATA_W, 16: sample width; two's complement.
- LOG2_N, 4: log2 of window length; N = 2^LOG2_N samples per result. Legal range 1..8.
- ACC_W, 2*DATA_W+LOG2_N: accumulator width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous abort of the current window.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed sample.
- out_valid  out  1  mean-square result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  2*DATA_W  unsigned mean-square result; feeds the square-root stage's 32-bit input.
- win_cnt  out  LOG2_N  number of samples accepted in the current window.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: all state updates only on the rising clk edge at which rst=1.
- Reset values:
  - state=ACCUM; out_valid=0; out_data=0; win_cnt=0.
  - accumulator=0; square register=0; sq_valid=0.
  - in_ready=0 while rst=1.
- Priority at each edge: rst, then flush, then the handshakes.
- Accept: an input transfer occurs when in_valid && in_ready.
- Stage 1 (square): on transfer, sq_q <= in_data*in_data, computed signed and stored unsigned in 2*DATA_W bits.
  - sq_valid <= 1 on a transfer, else 0.
  - Maximum square is (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2); no overflow.
- Stage 2 (accumulate): when sq_valid=1, acc <= acc + sq_q, zero-extended to ACC_W.
- win_cnt increments on each transfer and wraps N-1 -> 0 on the last sample of a window.
- State machine:
  - ACCUM: in_ready=1. A transfer with win_cnt==N-1 moves to FLUSH.
  - FLUSH: one cycle; in_ready=0.
    - At this edge: out_data <= (acc+sq_q)>>LOG2_N, truncated to 2*DATA_W bits.
    - Also: out_valid<=1, acc<=0, sq_valid<=0; go to HOLD.
  - HOLD: in_ready=0; out_valid=1; out_data held stable.
    - When out_valid && out_ready: out_valid<=0 and return to ACCUM.
    - in_ready rises the cycle after the acceptance; no same-cycle pass-through.
- Latency: out_valid is visible 2 cycles after the edge that accepted the Nth sample.
- Throughput: N samples per N+2 cycles when out_ready is held high.
- in_valid during FLUSH or HOLD is ignored; no sample is lost because in_ready=0 in those states.
- Result range: mean <= max square, so out_data <= 2^(2*DATA_W-2) = 0x40000000 at the defaults. Saturation logic is never needed.
- flush=1 in any state:
  - Clears acc, sq_valid, win_cnt and out_valid, and goes to ACCUM.
  - A sample presented in the same cycle is dropped, and in_ready=0 in that cycle.
  - A pending result in HOLD is discarded.
- rst mid-window or in HOLD: identical clearing effect; out_data returns to 0.
- in_data=0 for the whole window yields out_data=0 with normal handshake timing.

Optional Feature:
- Macro: RMS_ROUND_EN.
- Defined: the divide rounds half-up: out_data <= (acc+sq_q + 2^(LOG2_N-1))>>LOG2_N. The maximum result is still 2^(2*DATA_W-2).
- Undefined: the divide truncates (plain right shift). Timing and handshakes are identical in both builds.

Test Plan:
- Window value: 16 samples of 0x0100, out_ready=1 -> one result out_data=0x00010000; out_valid high 1 cycle, 2 cycles after the 16th accept; in_ready low for exactly 2 cycles.
- Extremes: 16 samples of 0x8000 -> 0x40000000. 16 samples alternating +3 and -3 (0x0003/0xFFFD) -> 0x00000009.
- Rounding: 8 samples of 0x0001 then 8 of 0x0000 -> out_data=0 without RMS_ROUND_EN; out_data=1 with it.
- Backpressure: complete a window with out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, in_ready=0, toggling in_valid has no effect. Raise out_ready -> single transfer, in_ready=1 the next cycle.
- Flush: 7 samples of 0x7FFF, then flush=1 with in_valid=1 -> win_cnt=0 and that sample dropped. Then 16 samples of 0x0002 -> out_data=0x00000004.
- Reset: rst=1 in HOLD with a pending result -> out_valid=0, out_data=0, win_cnt=0. After release, a full window of 0x0010 -> 0x00000100.

Source files
------------

// File: rtl/rms_window_accum.sv
// Windowed mean-square accumulator feeding the square-root stage: squares signed samples,
// sums N = 2^LOG2_N of them and shifts down. Define RMS_ROUND_EN to round the divide half-up.
module rms_window_accum #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*DATA_W-1:0]      out_data,
    output logic [LOG2_N-1:0]        win_cnt
);

    localparam int ACC_W = 2*DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        ACCUM,
        FLUSH,
        HOLD
    } state_t;

    state_t state, next_state;

    logic [2*DATA_W-1:0] sq_q;
    logic                sq_valid;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum_w;
    logic signed [2*DATA_W-1:0] din_ext;
    logic signed [2*DATA_W-1:0] sq_full;
    logic                xfer;

    // Sign-extend before multiplying so the full-width product is the true square.
    assign din_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign sq_full = din_ext * din_ext;
    assign xfer    = in_valid && in_ready;

`ifdef RMS_ROUND_EN
    assign sum_w = acc + {{LOG2_N{1'b0}}, sq_q} + (ACC_W'(1) << (LOG2_N - 1));
`else
    assign sum_w = acc + {{LOG2_N{1'b0}}, sq_q};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = !rst && !flush;
                if (xfer && win_cnt == LAST_IDX) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
        if (flush) begin
            next_state = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q     <= '0;
            sq_valid <= 1'b0;
            acc      <= '0;
            win_cnt  <= '0;
            out_data <= '0;
        end else if (flush) begin
            sq_valid <= 1'b0;
            acc      <= '0;
            win_cnt  <= '0;
        end else begin
            sq_valid <= xfer;
            if (xfer) begin
                sq_q    <= sq_full;
                win_cnt <= win_cnt + 1'b1;
            end
            // The last square is still in sq_q here, so it is folded in alongside acc.
            if (state == FLUSH) begin
                out_data <= (2*DATA_W)'(sum_w >> LOG2_N);
                acc      <= '0;
                sq_valid <= 1'b0;
            end else if (sq_valid) begin
                acc <= acc + {{LOG2_N{1'b0}}, sq_q};
            end
        end
    end

endmodule

// File: tb/tb_rms_window_accum.sv
// Scoreboard bench for rms_window_accum: a window-level mean-square model predicts each
// result and its appearance cycle; a negedge monitor compares whenever out_valid is high.
module tb_rms_window_accum;

    localparam int DATA_W = 16;
    localparam int LOG2_N = 4;
    localparam int N      = 1 << LOG2_N;

    typedef struct {
        logic [31:0] data;
        int          rise;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     flush = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [2*DATA_W-1:0]      out_data;
    logic [LOG2_N-1:0]        win_cnt;

    rms_window_accum #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .win_cnt  (win_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: window contents as a running sum of squares and a count.
    longint model_sum = 0;
    int     model_cnt = 0;
    exp_t   exp_q[$];

    // Inputs driven in the previous step, applied to the model at the edge they act on.
    logic                     pend_xfer = 1'b0;
    logic                     pend_flush = 1'b0;
    logic                     pend_rst = 1'b0;
    logic signed [DATA_W-1:0] pend_data = '0;

    int          hs_cnt = 0;
    logic [31:0] last_out = '0;
    bit          ov_prev = 1'b0;
    bit          hs_prev = 1'b0;
    bit          hs_now;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mean_of(input longint sum);
        longint rnd;
`ifdef RMS_ROUND_EN
        rnd = longint'(N / 2);
`else
        rnd = 0;
`endif
        return 32'((sum + rnd) / N);
    endfunction

    task automatic commit();
        exp_t e;
        if (pend_rst) begin
            model_sum = 0;
            model_cnt = 0;
            exp_q.delete();
        end else if (pend_flush) begin
            model_sum = 0;
            model_cnt = 0;
            exp_q.delete();
        end else if (pend_xfer) begin
            model_sum += longint'(pend_data) * longint'(pend_data);
            model_cnt++;
            if (model_cnt == N) begin
                e.data = mean_of(model_sum);
                e.rise = cyc + 1;
                exp_q.push_back(e);
                model_sum = 0;
                model_cnt = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic fl,
                        input logic rdy, input logic r);
        @(posedge clk);
        #1;
        commit();
        in_valid  = v;
        in_data   = d;
        flush     = fl;
        out_ready = rdy;
        rst       = r;
        #1;
        pend_xfer  = in_valid && in_ready;
        pend_data  = d;
        pend_flush = fl;
        pend_rst   = r;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic rdy);
        int b = 0;
        do begin
            step(1'b1, d, 1'b0, rdy, 1'b0);
            b++;
        end while (!pend_xfer && b < 20);
        if (!pend_xfer) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_n(input int n, input logic [DATA_W-1:0] d, input logic rdy);
        for (int i = 0; i < n; i++) send(d, rdy);
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp);
        int start = hs_cnt;
        int b = 0;
        while (hs_cnt == start && b < 12) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
            b++;
        end
        check({name, "_arrived"}, 64'(hs_cnt != start), 64'd1);
        check(name, 64'(last_out), 64'(exp));
    endtask

    always @(negedge clk) begin
        hs_now = 1'b0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                if (!ov_prev) check("result_latency", 64'(cyc), 64'(exp_q[0].rise));
                check("out_data", 64'(out_data), 64'(exp_q[0].data));
                check("in_ready_in_hold", 64'(in_ready), 64'd0);
                if (out_ready && !rst && !flush) begin
                    last_out = out_data;
                    hs_cnt++;
                    void'(exp_q.pop_front());
                    hs_now = 1'b1;
                end
            end
        end
        if (hs_prev && !rst && !flush) check("in_ready_after_accept", 64'(in_ready), 64'd1);
        check("win_cnt", 64'(win_cnt), 64'(model_cnt[LOG2_N-1:0]));
        ov_prev = out_valid;
        hs_prev = hs_now;
    end

    logic                rv;
    logic                rfl;
    logic                rrdy;
    logic [DATA_W-1:0]   rd;
    logic [31:0]         held;

    initial begin
        // Reset state.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("in_ready_during_rst", 64'(in_ready), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_win_cnt", 64'(win_cnt), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Known-answer windows.
        send_n(N, 16'h0100, 1'b1);
        wait_result("win_0100", 32'h0001_0000);
        send_n(N, 16'h8000, 1'b1);
        wait_result("win_8000", 32'h4000_0000);
        for (int i = 0; i < N; i++) send((i % 2 == 0) ? 16'h0003 : 16'hFFFD, 1'b1);
        wait_result("win_pm3", 32'h0000_0009);

        // Half-way rounding case.
        send_n(N / 2, 16'h0001, 1'b1);
        send_n(N / 2, 16'h0000, 1'b1);
`ifdef RMS_ROUND_EN
        wait_result("win_round", 32'h0000_0001);
`else
        wait_result("win_round", 32'h0000_0000);
`endif

        // Backpressure: result held while in_valid toggles.
        send_n(N, 16'h0200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'(i % 2), 16'h1234, 1'b0, 1'b0, 1'b0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        wait_result("win_bp", 32'h0004_0000);

        // Flush drops the concurrent sample and clears the window.
        send_n(7, 16'h7FFF, 1'b1);
        step(1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("flush_win_cnt", 64'(win_cnt), 64'd0);
        send_n(N, 16'h0002, 1'b1);
        wait_result("win_after_flush", 32'h0000_0004);

        // Reset while a result is pending in HOLD.
        send_n(N, 16'h1111, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        held = out_data;
        check("hold_pending", 64'(out_valid), 64'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("rst_hold_out_valid", 64'(out_valid), 64'd0);
        check("rst_hold_out_data", 64'(out_data), 64'd0);
        check("rst_hold_win_cnt", 64'(win_cnt), 64'd0);
        check("hold_value_seen", 64'(held), 64'(32'h0123_4321));
        send_n(N, 16'h0010, 1'b1);
        wait_result("win_after_rst", 32'h0000_0100);

        // Random traffic with sparse flushes and random backpressure.
        for (int i = 0; i < 3000; i++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rd   = DATA_W'($urandom);
            rfl  = ($urandom_range(0, 80) == 0);
            rrdy = ($urandom_range(0, 2) != 0);
            step(rv, rd, rfl, rrdy, 1'b0);
        end
        repeat (10) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
